// File: rtl/stage1b_prefetch_queue_if.sv
// Handshake bundle between the fetcher, the prefetch queue and the decoder.
// The queue uses the slave modport; the fetcher/decoder side uses master.
interface stage1b_prefetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_byte;
  logic [ADDR_W-1:0] in_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [LVL_W-1:0]  level;

  modport master (
    output in_valid, in_byte, in_addr, out_ready, flush, flush_pc,
    input  in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc, level
  );

  modport slave (
    input  in_valid, in_byte, in_addr, out_ready, flush, flush_pc,
    output in_ready, out_valid, out_instr, out_pc, redirect, redirect_pc, level
  );
endinterface

// File: rtl/stage1b_prefetch_queue.sv
// Prefetch queue: assembles the fetcher byte stream into 4-byte instructions
// tagged with the PC of their first byte and buffers them for the decoder.
// Optional feature: define PREFETCH_PREDECODE_JMP_EN to redirect the fetcher
// as soon as a jump opcode is assembled (target = {byte2,byte3}).
//
// state | meaning
// B0    | waiting for opcode byte (latches instruction PC)
// B1    | waiting for byte 1
// B2    | waiting for byte 2
// B3    | waiting for byte 3 (acceptance pushes into the FIFO)
module stage1b_prefetch_queue #(
  parameter int         DEPTH         = 4,
  parameter int         ADDR_W        = 10,
  parameter int         PROGRAM_START = 92,
  parameter logic [7:0] JMP_OPCODE    = 8'h01
) (
  input logic                     clk,
  input logic                     rst,
  stage1b_prefetch_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [ADDR_W-1:0] START_PC  = ADDR_W'(PROGRAM_START);

  typedef enum logic [1:0] {B0, B1, B2, B3} asm_state_t;

  asm_state_t        state, state_nxt;
  logic [7:0]        byte0_r, byte1_r, byte2_r;
  logic [ADDR_W-1:0] exp_addr, instr_pc;
  logic [31:0]       mem_instr [DEPTH];
  logic [ADDR_W-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level_r;
  logic              redirect_r;
  logic [ADDR_W-1:0] redirect_pc_r;
  logic              accept, in_seq, push, pop;

`ifdef PREFETCH_PREDECODE_JMP_EN
  logic              jmp_hit;
  logic [15:0]       jmp_word;
  logic [ADDR_W-1:0] jmp_target;
  assign jmp_hit    = push && (byte0_r == JMP_OPCODE);
  assign jmp_word   = {byte2_r, q.in_byte};
  assign jmp_target = ADDR_W'(jmp_word);
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The last assembly slot only blocks when there is no room to push into.
  assign q.in_ready    = (state != B3) || (level_r < LVL_FULL);
  assign accept        = q.in_valid && q.in_ready;
  assign in_seq        = accept && (q.in_addr == exp_addr);
  assign push          = in_seq && (state == B3);
  assign pop           = q.out_valid && q.out_ready;
  assign q.out_valid   = (level_r != '0);
  assign q.out_instr   = q.out_valid ? mem_instr[rd_ptr] : '0;
  assign q.out_pc      = q.out_valid ? mem_pc[rd_ptr] : '0;
  assign q.level       = level_r;
  assign q.redirect    = redirect_r;
  assign q.redirect_pc = redirect_pc_r;

  // Assembler state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= B0;
    else      state <= state_nxt;
  end

  // Assembler next state: in-order bytes advance, flush restarts at B0.
  always_comb begin
    state_nxt = state;
    if (q.flush) begin
      state_nxt = B0;
    end else if (in_seq) begin
      case (state)
        B0:      state_nxt = B1;
        B1:      state_nxt = B2;
        B2:      state_nxt = B3;
        default: state_nxt = B0;
      endcase
    end
  end

  // Byte capture, expected address, FIFO pointers/level and redirect pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte0_r       <= '0;
      byte1_r       <= '0;
      byte2_r       <= '0;
      instr_pc      <= '0;
      exp_addr      <= START_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level_r       <= '0;
      redirect_r    <= 1'b0;
      redirect_pc_r <= START_PC;
    end else begin
      redirect_r <= 1'b0;
      if (q.flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        level_r       <= '0;
        exp_addr      <= q.flush_pc;
        redirect_r    <= 1'b1;
        redirect_pc_r <= q.flush_pc;
      end else begin
        if (in_seq) begin
          exp_addr <= exp_addr + 1'b1;
          case (state)
            B0: begin
              byte0_r  <= q.in_byte;
              instr_pc <= q.in_addr;
            end
            B1:      byte1_r <= q.in_byte;
            B2:      byte2_r <= q.in_byte;
            default: ;
          endcase
        end
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        if (push && !pop)      level_r <= level_r + 1'b1;
        else if (pop && !push) level_r <= level_r - 1'b1;
`ifdef PREFETCH_PREDECODE_JMP_EN
        if (jmp_hit) begin
          exp_addr      <= jmp_target;
          redirect_r    <= 1'b1;
          redirect_pc_r <= jmp_target;
        end
`endif
      end
    end
  end

  // FIFO storage; the fourth byte goes straight in from the bus.
  always_ff @(posedge clk) begin
    if (push && !q.flush) begin
      mem_instr[wr_ptr] <= {byte0_r, byte1_r, byte2_r, q.in_byte};
      mem_pc[wr_ptr]    <= instr_pc;
    end
  end
endmodule

// File: tb/tb_stage1b_prefetch_queue.sv
module tb_stage1b_prefetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;
  localparam int PSTART = 92;
  localparam logic [7:0] JMP = 8'h01;

  typedef struct {
    logic [31:0] instr;
    int          pc;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stage1b_prefetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  stage1b_prefetch_queue #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .PROGRAM_START(PSTART), .JMP_OPCODE(JMP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .q  (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: partial instruction, expected address, expected FIFO
  item_t      sb[$];
  item_t      it;
  int         m_cnt   = 0;
  logic [7:0] m_b[4];
  int         m_pc    = 0;
  int         m_exp   = PSTART;
  bit         m_redir = 0;
  int         m_rpc   = PSTART;
  bit         m_rdy   = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    sb.delete();
    m_cnt   = 0;
    m_exp   = PSTART;
    m_redir = 0;
    m_rpc   = PSTART;
  endfunction

  // monitor: compare DUT against the model state, then retire a popped head
  initial forever begin
    @(negedge clk);
    m_rdy = (m_cnt != 3) || (sb.size() < DEPTH);
    chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
    chk("level", 32'(bus.level), sb.size());
    chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    chk("redirect", 32'(bus.redirect), 32'(m_redir));
    chk("redirect_pc", 32'(bus.redirect_pc), m_rpc);
    if (sb.size() != 0) begin
      chk("out_instr", bus.out_instr, sb[0].instr);
      chk("out_pc", 32'(bus.out_pc), sb[0].pc);
      if (bus.out_ready && rst) void'(sb.pop_front());
    end
  end

  // predictor: apply the upcoming edge's inputs to the model
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      model_reset();
    end else if (bus.flush) begin
      sb.delete();
      m_cnt   = 0;
      m_exp   = int'(bus.flush_pc);
      m_redir = 1;
      m_rpc   = int'(bus.flush_pc);
    end else begin
      m_redir = 0;
      if (bus.in_valid && m_rdy && int'(bus.in_addr) == m_exp) begin
        m_b[m_cnt] = bus.in_byte;
        if (m_cnt == 0) m_pc = m_exp;
        m_exp = (m_exp + 1) % 1024;
        m_cnt++;
        if (m_cnt == 4) begin
          it.instr = {m_b[0], m_b[1], m_b[2], m_b[3]};
          it.pc    = m_pc;
          sb.push_back(it);
          m_cnt = 0;
`ifdef PREFETCH_PREDECODE_JMP_EN
          if (m_b[0] == JMP) begin
            m_exp   = (int'(m_b[2]) * 256 + int'(m_b[3])) % 1024;
            m_redir = 1;
            m_rpc   = m_exp;
          end
`endif
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int a);
    bit acc = 0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_addr  = a[9:0];
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_byte_timeout addr=%0d got=no_accept want=accept", a);
    end
  endtask

  task automatic send_instr(input logic [31:0] w, input int pc);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], (pc + k) % 1024);
  endtask

  task automatic do_flush(input int pc);
    bus.flush    = 1'b1;
    bus.flush_pc = pc[9:0];
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    model_reset();
    @(negedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_pc", 32'(bus.out_pc), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_redirect", 32'(bus.redirect), 0);
    chk("rst_redirect_pc", 32'(bus.redirect_pc), 92);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_byte   = '0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    idle(2);
    do_reset();

    // single instruction, held at the head
    send_instr(32'h0403002A, 92);
    chk("t2_out_valid", 32'(bus.out_valid), 1);
    chk("t2_out_instr", bus.out_instr, 32'h0403002A);
    chk("t2_out_pc", 32'(bus.out_pc), 92);
    chk("t2_level", 32'(bus.level), 1);
    bus.out_ready = 1'b1;
    idle(3);

    // mid-stream reset, then backpressure with five instructions
    send_byte(8'h77, 96);
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send_instr(32'h10203040 + 32'(i), 92 + 4 * i);
      end
      begin
        idle(60);
        chk("t3_full_level", 32'(bus.level), 4);
        chk("t3_full_in_ready", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
      end
    join
    idle(10);

    // flush in the middle of an instruction
    do_reset();
    bus.out_ready = 1'b1;
    send_byte(8'h11, 92);
    send_byte(8'h22, 93);
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h33;
    bus.in_addr  = 10'd94;
    do_flush(200);
    bus.in_valid = 1'b0;
    chk("t4_redirect", 32'(bus.redirect), 1);
    chk("t4_redirect_pc", 32'(bus.redirect_pc), 200);
    chk("t4_level", 32'(bus.level), 0);
    send_byte(8'h44, 94);
    send_byte(8'h55, 95);
    send_instr(32'hAABBCCDD, 200);
    idle(4);

    // address wrap, then fill and release with push+pop on one edge
    bus.out_ready = 1'b0;
    do_flush(1022);
    send_instr(32'hC0FFEE02, 1022);
    chk("t5_out_pc", 32'(bus.out_pc), 1022);
    send_instr(32'h21222324, 2);
    send_instr(32'h31323334, 6);
    send_instr(32'h41424344, 10);
    send_byte(8'h51, 14);
    send_byte(8'h52, 15);
    send_byte(8'h53, 16);
    fork
      send_byte(8'h54, 17);
      begin
        idle(3);
        bus.out_ready = 1'b1;
      end
    join
    idle(8);

    // jump predecode
    do_reset();
    bus.out_ready = 1'b1;
    send_instr(32'h010000C8, 92);
`ifdef PREFETCH_PREDECODE_JMP_EN
    chk("t6_redirect", 32'(bus.redirect), 1);
    chk("t6_redirect_pc", 32'(bus.redirect_pc), 200);
`else
    chk("t6_redirect", 32'(bus.redirect), 0);
    chk("t6_redirect_pc", 32'(bus.redirect_pc), 92);
`endif
    send_instr(32'h05060708, 96);
    send_instr(32'h0A0B0C0D, 200);
    idle(4);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_byte   = (m_cnt == 0 && $urandom_range(0, 7) == 0) ? JMP : 8'($urandom);
      bus.in_addr   = ($urandom_range(0, 9) < 8) ? 10'(m_exp) : 10'($urandom_range(0, 1023));
      bus.out_ready = ((i / 150) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.flush_pc  = 10'($urandom_range(0, 1023));
      idle(1);
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL global_timeout got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "time limit");
  end
endmodule
